led_status_pwm: RTL and testbench
=================================

# led_status_pwm

Parametrised multi-channel LED status driver for the iCE40 boards. It converts per-channel mode/level configuration into glitch-free PWM waveforms that feed the RGB0PWM..RGB2PWM inputs of the on-chip RGB LED driver. Each channel can be off, solid, blinking or breathing, replacing the raw three-bit status wires the bench currently drives into the LED driver. It sits between the test/status logic and the LED driver primitive in the chip top level.

## Interface
- NUM_CH, 3: number of PWM channels (1..8).
- PWM_BITS, 8: PWM counter and level width (2..12).
- PRESCALE, 1: clocks per PWM count (>=1); period = PRESCALE * 2^PWM_BITS clocks.
- BLINK_BITS, 6: blink counter width in PWM periods (>=1).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- i_cfg_we  in  1  config write strobe, one cycle.
- i_cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel; out-of-range index is ignored.
- i_cfg_mode  in  2  0=OFF, 1=SOLID, 2=BLINK, 3=BREATHE.
- i_cfg_level  in  PWM_BITS  brightness/peak duty.
- o_pwm  out  NUM_CH  PWM outputs, bit n = channel n.
- o_period  out  1  one-cycle pulse on each period boundary.

Clock is named clk and reset is named reset. Reset is asynchronous and active-high.

## Operation
- Prescaler counts 0..PRESCALE-1. tick is asserted when it wraps. With PRESCALE=1, tick is asserted every cycle.
- pwm_cnt (PWM_BITS) increments on tick and wraps modulo 2^PWM_BITS.
- Period boundary: tick && pwm_cnt == 2^PWM_BITS-1.
- blink_cnt (BLINK_BITS) increments at each boundary. blink_on = MSB of blink_cnt.
- Each channel has two register sets:
  - Shadow mode/level: written when i_cfg_we is high and i_cfg_ch matches.
  - Active mode/level: copied from shadow at each boundary.
- A write in the boundary cycle itself lands in shadow and takes effect at the following boundary. Only the last write to a channel before a boundary counts.
- Duty per channel:
  - OFF: 0.
  - SOLID: level.
  - BLINK: level if blink_on, else 0.
  - BREATHE: ramp.
- Breathe ramp: per-channel ramp (PWM_BITS) plus direction state UP/DOWN. It updates at each boundary while the active mode is BREATHE.
  - UP: if ramp == level, go DOWN and ramp = level-1; otherwise ramp+1.
  - DOWN: if ramp == 0, go UP and ramp = 1; otherwise ramp-1.
  - With level 0, ramp holds at 0.
- Mode load into BREATHE from any other mode: ramp=0, UP.
- Level load below the current ramp while breathing: ramp clamps to the new level, direction becomes DOWN.
- o_pwm[n] is registered and equals (pwm_cnt < duty_n). Duty 0 gives constant low; duty 2^PWM_BITS-1 gives high for all but one count.
- No arithmetic exceeds PWM_BITS. All counters wrap silently.

## Timing
- Reset values: o_pwm=0, o_period=0, all counters 0, shadow and active = OFF/level 0, ramp=0, direction UP.
- o_pwm lags pwm_cnt by one clock.
- o_period is registered and high for exactly one clock, in the cycle after the boundary.
- The duty of a whole period uses the active values loaded at its opening boundary. Outputs never change duty mid-period.
- The first period after reset runs with OFF on all channels.
- Reset asserted mid-period forces all outputs low asynchronously. After release, operation restarts from count 0.

## Structure
- Shared package led_pkg holds:
  - Mode constants MODE_OFF, MODE_SOLID, MODE_BLINK, MODE_BREATHE.
  - The 2-bit mode typedef.
- The top level holds the prescaler, pwm_cnt, blink_cnt, boundary and o_period logic.
- Sub-module led_pwm_channel is instantiated NUM_CH times. Each instance holds its shadow/active registers, ramp FSM and comparator.
- The chip top level instantiates led_status_pwm with NUM_CH=3 and wires o_pwm to RGB0PWM..RGB2PWM.

## Test plan
All scenarios use PWM_BITS=4, PRESCALE=1, BLINK_BITS=2, NUM_CH=3, giving a 16-clock period.
- Reset, then SOLID level 5 on ch0: from the second boundary on, o_pwm[0] is high for 5 of every 16 clocks. Write level 0: constant low. Write level 15: high 15 of 16.
- BLINK level 8 on ch1: per period, duty alternates 2 periods at 0 and 2 periods at 8, following the blink_cnt MSB. ch0 and ch2 stay low.
- BREATHE level 3 on ch2: successive period duties are 0,1,2,3,2,1,0,1,2… While ramp=3, write level 1: next duty is 1, then 0, 1, 0…
- Write ch0 SOLID 10 at count 7, then SOLID 2 at count 12: the current period is unchanged and the next period has duty 2. A write in the boundary cycle applies one period later.
- PRESCALE=3: the period is 48 clocks and o_period pulses every 48 clocks. Writing i_cfg_ch=3 has no effect.
- Assert reset mid-period with all channels SOLID 15: o_pwm=0 immediately. After release, all outputs stay low for the first full period.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the LED status PWM driver: channel modes and breathe direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: shadow/active config, breathe ramp FSM and duty comparator.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  mode_t               cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_level,
    input  logic                boundary,
    input  logic                blink_on,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm
);

    typedef struct packed {
        mode_t               mode;
        logic [PWM_BITS-1:0] level;
    } cfg_t;

    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    cfg_t                shadow, active;
    dir_t                dir, dir_nxt;
    logic [PWM_BITS-1:0] ramp, ramp_nxt;
    logic [PWM_BITS-1:0] duty;

    // Active only moves at the period boundary, so a period never sees a duty change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '{mode: MODE_OFF, level: '0};
            active <= '{mode: MODE_OFF, level: '0};
        end else begin
            if (cfg_we)   shadow <= '{mode: cfg_mode, level: cfg_level};
            if (boundary) active <= shadow;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir  <= DIR_UP;
            ramp <= '0;
        end else begin
            dir  <= dir_nxt;
            ramp <= ramp_nxt;
        end
    end

    // Ramp steps against the config being loaded this boundary, so a level
    // change and the step it affects happen together.
    always_comb begin
        dir_nxt  = dir;
        ramp_nxt = ramp;
        if (boundary && shadow.mode == MODE_BREATHE) begin
            if (active.mode != MODE_BREATHE) begin
                dir_nxt  = DIR_UP;
                ramp_nxt = '0;
            end else if (shadow.level < ramp) begin
                dir_nxt  = DIR_DOWN;
                ramp_nxt = shadow.level;
            end else if (shadow.level == '0) begin
                ramp_nxt = '0;
            end else begin
                case (dir)
                    DIR_UP: begin
                        if (ramp == shadow.level) begin
                            dir_nxt  = DIR_DOWN;
                            ramp_nxt = shadow.level - ONE;
                        end else begin
                            ramp_nxt = ramp + ONE;
                        end
                    end
                    default: begin
                        if (ramp == '0) begin
                            dir_nxt  = DIR_UP;
                            ramp_nxt = ONE;
                        end else begin
                            ramp_nxt = ramp - ONE;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        duty = '0;
        case (active.mode)
            MODE_SOLID:   duty = active.level;
            MODE_BLINK:   duty = blink_on ? active.level : '0;
            MODE_BREATHE: duty = ramp;
            default:      duty = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm <= 1'b0;
        else       pwm <= (pwm_cnt < duty);
    end

endmodule

// File: rtl/led_status_pwm.sv
// Multi-channel LED status PWM driver: shared timebase plus one channel instance per LED.
module led_status_pwm
    import led_pkg::*;
#(
    parameter  int NUM_CH     = 3,
    parameter  int PWM_BITS   = 8,
    parameter  int PRESCALE   = 1,
    parameter  int BLINK_BITS = 6,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_cfg_we,
    input  logic [CH_W-1:0]     i_cfg_ch,
    input  logic [1:0]          i_cfg_mode,
    input  logic [PWM_BITS-1:0] i_cfg_level,
    output logic [NUM_CH-1:0]   o_pwm,
    output logic                o_period
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0]      pre_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  tick, boundary, blink_on;

    assign tick     = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign boundary = tick && (pwm_cnt == '1);
    assign blink_on = blink_cnt[BLINK_BITS-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            o_period  <= 1'b0;
        end else begin
            pre_cnt  <= tick ? '0 : pre_cnt + PRE_W'(1);
            o_period <= boundary;
            if (tick)     pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            if (boundary) blink_cnt <= blink_cnt + BLINK_BITS'(1);
        end
    end

    // Channel select by exact index match; indices >= NUM_CH hit nothing.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(g);
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .cfg_we    (i_cfg_we && (i_cfg_ch == IDX)),
            .cfg_mode  (mode_t'(i_cfg_mode)),
            .cfg_level (i_cfg_level),
            .boundary  (boundary),
            .blink_on  (blink_on),
            .pwm_cnt   (pwm_cnt),
            .pwm       (o_pwm[g])
        );
    end

endmodule

// File: tb/tb_led_status_pwm.sv
// Scoreboard bench: a period-level model pushes expected duties, a monitor captures each period's waveform.
module tb_led_status_pwm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b0, we3 = 1'b0;
    logic [1:0] ch = '0, mode = '0;
    logic [3:0] lvl = '0;
    logic [2:0] pwm, pwm3;
    logic       per, per3;

    always #5 clk = ~clk;

    led_status_pwm #(.NUM_CH(3), .PWM_BITS(4), .PRESCALE(1), .BLINK_BITS(2)) dut (
        .clk(clk), .reset(reset), .i_cfg_we(we), .i_cfg_ch(ch), .i_cfg_mode(mode),
        .i_cfg_level(lvl), .o_pwm(pwm), .o_period(per)
    );

    led_status_pwm #(.NUM_CH(3), .PWM_BITS(4), .PRESCALE(3), .BLINK_BITS(2)) dut3 (
        .clk(clk), .reset(reset), .i_cfg_we(we3), .i_cfg_ch(ch), .i_cfg_mode(mode),
        .i_cfg_level(lvl), .o_pwm(pwm3), .o_period(per3)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef logic [2:0][3:0] duty_t;
    duty_t exp_q[$];

    // Period-level reference model
    int sh_m[3], sh_l[3], ac_m[3], ac_l[3], rmp[3], dn[3];
    int blink, pos;
    bit pend;
    int pend_ch, pend_m, pend_l;

    task automatic m_reset();
        for (int n = 0; n < 3; n++) begin
            sh_m[n] = 0; sh_l[n] = 0; ac_m[n] = 0; ac_l[n] = 0; rmp[n] = 0; dn[n] = 0;
        end
        blink = 0; pend = 0; pos = 0;
    endtask

    task automatic m_write(input int c, input int m, input int l);
        if (c < 3) begin
            sh_m[c] = m; sh_l[c] = l;
        end
    endtask

    task automatic m_boundary();
        duty_t e;
        int    d;
        blink = (blink + 1) % 4;
        for (int n = 0; n < 3; n++) begin
            if (sh_m[n] == 3) begin
                if (ac_m[n] != 3) begin
                    rmp[n] = 0; dn[n] = 0;
                end else if (sh_l[n] < rmp[n]) begin
                    rmp[n] = sh_l[n]; dn[n] = 1;
                end else if (sh_l[n] == 0) begin
                    rmp[n] = 0;
                end else if (dn[n] == 0) begin
                    if (rmp[n] == sh_l[n]) begin dn[n] = 1; rmp[n] = sh_l[n] - 1; end
                    else rmp[n] = rmp[n] + 1;
                end else begin
                    if (rmp[n] == 0) begin dn[n] = 0; rmp[n] = 1; end
                    else rmp[n] = rmp[n] - 1;
                end
            end
            ac_m[n] = sh_m[n];
            ac_l[n] = sh_l[n];
            case (ac_m[n])
                1:       d = ac_l[n];
                2:       d = (blink >= 2) ? ac_l[n] : 0;
                3:       d = rmp[n];
                default: d = 0;
            endcase
            e[n] = 4'(d);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: sample k after an o_period pulse is the output for count k-1;
    // the next pulse's sample closes the window with count 15.
    logic [2:0][15:0] wv;
    int    mpos;
    bit    armed, mon_en = 1'b0;
    duty_t e_pop;

    function automatic logic [15:0] mk(input logic [3:0] d);
        logic [31:0] one = 32'd1;
        return 16'((one << d) - one);
    endfunction

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            armed = 1'b0; mpos = 0; wv = '0;
        end else begin
            if (mpos < 16) for (int n = 0; n < 3; n++) wv[n][mpos] = pwm[n];
            mpos++;
            if (per) begin
                if (!armed) begin
                    chk("first_low", {29'b0, |wv[2], |wv[1], |wv[0]}, 32'd0);
                    armed = 1'b1;
                end else if (exp_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e_pop = exp_q.pop_front();
                    for (int n = 0; n < 3; n++)
                        chk($sformatf("wave_ch%0d", n), {16'b0, wv[n]}, {16'b0, mk(e_pop[n])});
                    chk("period_len", mpos, 32'd16);
                end
                mpos = 0; wv = '0;
            end
        end
    end

    task automatic wait_period();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!per && t < 100);
        if (!per) chk("period_timeout", 32'd0, 32'd1);
        pos = 0;
        m_boundary();
        if (pend) begin
            m_write(pend_ch, pend_m, pend_l);
            pend = 0;
        end
    endtask

    task automatic goto(input int c);
        if (c > pos) repeat (c - pos) @(negedge clk);
        pos = c;
    endtask

    // Write in cycle with pwm_cnt == c; c == 15 is the boundary cycle.
    task automatic wr(input int c, input int chn, input int m, input int l);
        goto(c);
        ch = 2'(chn); mode = 2'(m); lvl = 4'(l); we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
        if (c == 15) begin
            pend = 1; pend_ch = chn; pend_m = m; pend_l = l;
        end else begin
            m_write(chn, m, l);
        end
    endtask

    task automatic wait_n(input int k);
        repeat (k) wait_period();
    endtask

    initial begin
        bit hit;
        int t, any3;
        m_reset();
        #12;
        chk("rst_pwm", {29'b0, pwm}, 32'd0);
        chk("rst_period", {31'b0, per}, 32'd0);
        chk("rst_pwm3", {29'b0, pwm3}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        mon_en = 1'b1;

        // SOLID 5, then 0, then 15 on ch0
        wait_period();
        wr(3, 0, 1, 5);   wait_n(3);
        wr(2, 0, 1, 0);   wait_n(2);
        wr(2, 0, 1, 15);  wait_n(2);

        // BLINK 8 on ch1
        wr(1, 0, 0, 0);
        wr(2, 1, 2, 8);   wait_n(5);

        // BREATHE 3 on ch2, then drop level to 1 while ramp sits at 3
        wr(1, 1, 0, 0);
        wr(2, 2, 3, 3);
        wait_period();
        hit = 0;
        for (int i = 0; i < 8 && !hit; i++) begin
            wait_period();
            if (ac_m[2] == 3 && rmp[2] == 3) begin
                wr(4, 2, 3, 1);
                hit = 1;
            end
        end
        chk("ramp_peak_seen", {31'b0, hit}, 32'd1);
        wait_n(5);

        // Mid-period rewrites: last write wins; boundary-cycle write lands a period late
        wr(1, 2, 0, 0);
        wait_period();
        wr(7, 0, 1, 10);
        wr(12, 0, 1, 2);  wait_n(2);
        wr(15, 0, 1, 9);  wait_n(3);

        // All SOLID 15, then asynchronous reset mid-period
        wr(1, 0, 1, 15);
        wr(2, 1, 1, 15);
        wr(3, 2, 1, 15);
        wait_n(3);
        goto(7);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pwm", {29'b0, pwm}, 32'd0);
        chk("async_rst_period", {31'b0, per}, 32'd0);
        exp_q.delete();
        m_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_n(3);
        mon_en = 1'b0;

        // PRESCALE=3 instance: 48-clock period, out-of-range channel ignored
        @(negedge clk);
        ch = 2'd3; mode = 2'd1; lvl = 4'd15; we3 = 1'b1;
        @(posedge clk);
        #1 we3 = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!per3 && t < 200);
        chk("per3_first", {31'b0, per3}, 32'd1);
        any3 = 0;
        for (int i = 0; i < 3; i++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
                any3 = any3 | int'(pwm3);
            end while (!per3 && t < 200);
            chk("per3_len", t, 32'd48);
        end
        chk("ch3_ignored", any3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
